wm_cycle_ctrl: RTL and testbench

Parametrised coin-operated washing-machine cycle controller: the next generation of the team's single-program washer FSM. It accumulates coin credit and runs a timed FILL → WASH → RINSE → SPIN sequence. Wash length is selectable per run, extra wash/rinse passes are bounded, and a lid-open interlock pauses the run. It sits between the panel inputs (coin acceptor, lid switch, program selector) and the drum/valve drivers, which decode `state`.

---
 rtl/wm_pkg.sv | 31 +++
 rtl/wm_cycle_ctrl_if.sv | 28 ++
 rtl/wm_phase_timer.sv | 35 +++
 rtl/wm_cycle_ctrl.sv | 143 ++++++++++++++
 tb/tb_wm_cycle_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wm_pkg.sv
// Shared types for the washing-machine cycle controller: drum/valve state
// encodings, program-select values and the wash-length multiplier.
package wm_pkg;

   // State encodings are decoded directly by the drum/valve drivers.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      MODE_QUICK  = 2'd0,
      MODE_NORMAL = 2'd1,
      MODE_HEAVY  = 2'd2,
      MODE_RSVD   = 2'd3
   } mode_e;

   // Wash length multiplier; the unused selector value runs as normal.
   function automatic int unsigned wash_mult(input mode_e m);
      case (m)
         MODE_QUICK: return 1;
         MODE_HEAVY: return 3;
         default:    return 2;
      endcase
   endfunction

endpackage

// File: rtl/wm_cycle_ctrl_if.sv
// Panel-to-controller bundle: coin/lid/program inputs and the registered
// status outputs that feed the drum and valve drivers.
interface wm_cycle_ctrl_if #(
   parameter int CNT_W = 8
) ();
   logic             coin;
   logic             lid_open;
   logic             second_wash;
   logic [1:0]       mode;
   logic [2:0]       state;
   logic [CNT_W-1:0] time_left;
   logic [3:0]       credit;
   logic             door_lock;
   logic             paused;
   logic             done;

   // Panel side: drives the inputs, observes the status.
   modport master (
      output coin, lid_open, second_wash, mode,
      input  state, time_left, credit, door_lock, paused, done
   );

   // Controller side.
   modport slave (
      input  coin, lid_open, second_wash, mode,
      output state, time_left, credit, door_lock, paused, done
   );
endinterface

// File: rtl/wm_phase_timer.sv
// Phase down-counter: load has priority, otherwise counts down once per
// enabled cycle and parks at zero. zero_o flags the final cycle of a phase.
module wm_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o,
   output logic             zero_o
);
   logic [CNT_W-1:0] count_q, count_d;

   // Next count: reload on phase entry, otherwise decrement when enabled.
   always_comb begin
      count_d = count_q;
      if (load_i)
         count_d = load_val_i;
      else if (en_i && count_q != '0)
         count_d = count_q - CNT_W'(1);
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);
endmodule

// File: rtl/wm_cycle_ctrl.sv
// Coin-operated washer controller: accumulates credit, then runs
// FILL -> WASH -> RINSE (-> WASH ...) -> SPIN -> DONE with a lid interlock
// that freezes the run while the lid is open.
module wm_cycle_ctrl
   import wm_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int PRICE     = 2,
   parameter int FILL_T    = 4,
   parameter int WASH_T    = 8,
   parameter int RINSE_T   = 6,
   parameter int SPIN_T    = 5,
   parameter int MAX_EXTRA = 3
) (
   input  logic          clk,
   input  logic          rst,
   wm_cycle_ctrl_if.slave bus
);
   localparam logic [3:0] PRICE_C = 4'(PRICE);
   localparam int         EXW     = (MAX_EXTRA < 1) ? 1 : $clog2(MAX_EXTRA + 1);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [3:0]       credit_q, credit_d, credit_sum;
   logic [EXW-1:0]   extra_q, extra_d;
   logic             paused_q, paused_d;
   logic             lock_q, lock_d;
   logic             done_q, done_d;
   logic             in_run;

   logic             tmr_load, tmr_en, tmr_zero;
   logic [CNT_W-1:0] tmr_val, tmr_count, wash_len;

   // Wash phase reload value for the program latched at start.
   assign wash_len = CNT_W'(WASH_T * wash_mult(mode_q) - 1);
   assign in_run   = state_q inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN};

   wm_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .en_i      (tmr_en),
      .count_o   (tmr_count),
      .zero_o    (tmr_zero)
   );

   // Next-state, credit, pass count and timer control. An open lid blocks
   // both the countdown and the phase exit, so a pause always wins over exit.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      credit_d   = credit_q;
      extra_d    = extra_q;
      credit_sum = credit_q;
      tmr_load   = 1'b0;
      tmr_en     = 1'b0;
      tmr_val    = '0;

      case (state_q)
         ST_IDLE: begin
            if (bus.coin && credit_q < PRICE_C)
               credit_sum = credit_q + 4'd1;
            credit_d = credit_sum;
            if (credit_sum == PRICE_C && !bus.lid_open) begin
               state_d  = ST_FILL;
               credit_d = '0;
               mode_d   = mode_e'(bus.mode);
               extra_d  = '0;
               tmr_load = 1'b1;
               tmr_val  = CNT_W'(FILL_T - 1);
            end
         end
         ST_FILL, ST_WASH, ST_RINSE, ST_SPIN: begin
            if (!bus.lid_open) begin
               if (!tmr_zero) begin
                  tmr_en = 1'b1;
               end else begin
                  tmr_load = 1'b1;
                  case (state_q)
                     ST_FILL: begin
                        state_d = ST_WASH;
                        tmr_val = wash_len;
                     end
                     ST_WASH: begin
                        state_d = ST_RINSE;
                        tmr_val = CNT_W'(RINSE_T - 1);
                     end
                     ST_RINSE: begin
                        if (bus.second_wash && extra_q < EXW'(MAX_EXTRA)) begin
                           state_d = ST_WASH;
                           tmr_val = wash_len;
                           extra_d = extra_q + EXW'(1);
                        end else begin
                           state_d = ST_SPIN;
                           tmr_val = CNT_W'(SPIN_T - 1);
                        end
                     end
                     default: begin
                        state_d = ST_DONE;
                        tmr_val = '0;
                     end
                  endcase
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      paused_d = in_run && bus.lid_open;
      lock_d   = state_d inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN};
      done_d   = (state_d == ST_DONE);
   end

   // Controller registers; reset aborts any run and drops held credit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_QUICK;
         credit_q <= '0;
         extra_q  <= '0;
         paused_q <= 1'b0;
         lock_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         credit_q <= credit_d;
         extra_q  <= extra_d;
         paused_q <= paused_d;
         lock_q   <= lock_d;
         done_q   <= done_d;
      end
   end

   assign bus.state     = state_q;
   assign bus.time_left = tmr_count;
   assign bus.credit    = credit_q;
   assign bus.door_lock = lock_q;
   assign bus.paused    = paused_q;
   assign bus.done      = done_q;
endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Directed bench for wm_cycle_ctrl with default parameters: a per-cycle
// vector table for credit/start/pause, then hand sequences for whole runs.
module tb_wm_cycle_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;

   wm_cycle_ctrl_if #(.CNT_W(8)) bus ();

   wm_cycle_ctrl dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       coin;
      logic       lid;
      logic       sw;
      logic [1:0] mode;
      logic [2:0] st;
      logic [7:0] tl;
      logic [3:0] cr;
      logic       lock;
      logic       pau;
      logic       dn;
   } vec_t;

   vec_t vecs[11];

   int checks = 0;
   int failures = 0;
   int edges = 0;
   int start_edge = 0;
   int done_hits = 0;
   int pause_cnt = 0;
   int st_cnt[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_counts();
      for (int i = 0; i < 8; i++) st_cnt[i] = 0;
      done_hits = 0;
      pause_cnt = 0;
   endtask

   // Advance one clock and sample 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
      edges++;
      st_cnt[bus.state]++;
      if (bus.done) done_hits++;
      if (bus.paused) pause_cnt++;
   endtask

   // Two coins; the second one starts the run on its own edge.
   task automatic do_start(input logic [1:0] m);
      bus.mode = m;
      bus.coin = 1'b1;
      step();
      clear_counts();
      step();
      bus.coin = 1'b0;
      start_edge = edges;
      check("start_state", 32'(bus.state), 32'd1);
      check("start_tl", 32'(bus.time_left), 32'd3);
      check("start_credit", 32'(bus.credit), 32'd0);
      check("start_lock", 32'(bus.door_lock), 32'd1);
   endtask

   // Run until done (bounded), check run length and the return to IDLE.
   task automatic finish_run(input string tag, input int exp_len);
      while (bus.done !== 1'b1 && (edges - start_edge) < 200) step();
      check({tag, "_len"}, 32'(edges - start_edge), 32'(exp_len));
      check({tag, "_lock_in_done"}, 32'(bus.door_lock), 32'd0);
      step();
      check({tag, "_idle"}, 32'(bus.state), 32'd0);
      check({tag, "_done_low"}, 32'(bus.done), 32'd0);
      check({tag, "_credit0"}, 32'(bus.credit), 32'd0);
      check({tag, "_done_once"}, 32'(done_hits), 32'd1);
      $display("run %s: length=%0d wash=%0d rinse=%0d spin=%0d", tag,
               edges - start_edge - 1, st_cnt[2], st_cnt[3], st_cnt[4]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //               coin  lid   sw    mode   st    tl      cr    lock  pau   dn
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0,  4'd1, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0,  4'd1, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0,  4'd2, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd0, 3'd0, 8'd0,  4'd2, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 8'd3,  4'd0, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 2'd2, 3'd1, 8'd2,  4'd0, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 8'd1,  4'd0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 3'd1, 8'd0,  4'd0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 8'd23, 4'd0, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'd2, 8'd23, 4'd0, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 8'd22, 4'd0, 1'b1, 1'b0, 1'b0};

      bus.coin = 1'b0;
      bus.lid_open = 1'b0;
      bus.second_wash = 1'b0;
      bus.mode = 2'd0;
      clear_counts();

      // Reset, with a coin arriving during reset: reset wins.
      rst = 1'b1;
      step();
      bus.coin = 1'b1;
      step();
      check("rst_state", 32'(bus.state), 32'd0);
      check("rst_tl", 32'(bus.time_left), 32'd0);
      check("rst_credit", 32'(bus.credit), 32'd0);
      check("rst_lock", 32'(bus.door_lock), 32'd0);
      check("rst_paused", 32'(bus.paused), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      bus.coin = 1'b0;
      rst = 1'b0;

      // Credit with open lid, start on lid close, mode latch, one-cycle pause.
      for (int i = 0; i < 11; i++) begin
         bus.coin = vecs[i].coin;
         bus.lid_open = vecs[i].lid;
         bus.second_wash = vecs[i].sw;
         bus.mode = vecs[i].mode;
         step();
         $display("vec %0d: state=%0d time_left=%0d credit=%0d lock=%0d paused=%0d done=%0d",
                  i, bus.state, bus.time_left, bus.credit, bus.door_lock, bus.paused, bus.done);
         check($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
         check($sformatf("vec%0d_tl", i), 32'(bus.time_left), 32'(vecs[i].tl));
         check($sformatf("vec%0d_credit", i), 32'(bus.credit), 32'(vecs[i].cr));
         check($sformatf("vec%0d_lock", i), 32'(bus.door_lock), 32'(vecs[i].lock));
         check($sformatf("vec%0d_paused", i), 32'(bus.paused), 32'(vecs[i].pau));
         check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].dn));
      end
      bus.coin = 1'b0;
      bus.lid_open = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;

      // Basic quick run.
      do_start(2'd0);
      finish_run("basic", 23);
      check("basic_fill", 32'(st_cnt[1]), 32'd4);
      check("basic_wash", 32'(st_cnt[2]), 32'd8);
      check("basic_rinse", 32'(st_cnt[3]), 32'd6);
      check("basic_spin", 32'(st_cnt[4]), 32'd5);

      // Heavy program; selector changes mid-run are ignored.
      do_start(2'd2);
      bus.mode = 2'd0;
      finish_run("heavy", 39);
      check("heavy_wash", 32'(st_cnt[2]), 32'd24);

      // Lid open for 3 cycles during WASH at time_left=5.
      do_start(2'd0);
      for (int i = 0; i < 40; i++) begin
         if (bus.state == 3'd2 && bus.time_left == 8'd5) break;
         step();
      end
      check("pause_reach_state", 32'(bus.state), 32'd2);
      check("pause_reach_tl", 32'(bus.time_left), 32'd5);
      bus.lid_open = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("pause%0d_paused", i), 32'(bus.paused), 32'd1);
         check($sformatf("pause%0d_tl", i), 32'(bus.time_left), 32'd5);
         check($sformatf("pause%0d_lock", i), 32'(bus.door_lock), 32'd1);
         check($sformatf("pause%0d_state", i), 32'(bus.state), 32'd2);
      end
      bus.lid_open = 1'b0;
      step();
      check("resume_paused", 32'(bus.paused), 32'd0);
      check("resume_tl", 32'(bus.time_left), 32'd4);
      finish_run("pause", 26);
      check("pause_wash", 32'(st_cnt[2]), 32'd11);
      check("pause_cycles", 32'(pause_cnt), 32'd3);

      // Extra passes requested throughout: bounded at three.
      bus.second_wash = 1'b1;
      do_start(2'd0);
      finish_run("extra", 65);
      check("extra_wash", 32'(st_cnt[2]), 32'd32);
      check("extra_rinse", 32'(st_cnt[3]), 32'd24);
      check("extra_spin", 32'(st_cnt[4]), 32'd5);
      bus.second_wash = 1'b0;

      // Reset in the middle of RINSE, coin asserted on the same edge.
      do_start(2'd0);
      for (int i = 0; i < 40; i++) begin
         if (bus.state == 3'd3) break;
         step();
      end
      check("midrst_reach", 32'(bus.state), 32'd3);
      step();
      rst = 1'b1;
      bus.coin = 1'b1;
      step();
      check("midrst_state", 32'(bus.state), 32'd0);
      check("midrst_tl", 32'(bus.time_left), 32'd0);
      check("midrst_credit", 32'(bus.credit), 32'd0);
      check("midrst_lock", 32'(bus.door_lock), 32'd0);
      check("midrst_paused", 32'(bus.paused), 32'd0);
      check("midrst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;
      bus.coin = 1'b0;
      for (int i = 0; i < 30; i++) step();
      check("midrst_no_done", 32'(done_hits), 32'd0);
      check("midrst_idle", 32'(bus.state), 32'd0);
      $display("run reset: state=%0d credit=%0d done_pulses=%0d", bus.state, bus.credit, done_hits);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
